// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 16x-oversampling UART byte receiver that splits each good byte
// into an address/data command held under a valid/ack handshake.
// Optional parity bit compiled in with `define UART_CMD_RX_PARITY_EN.
module uart_cmd_rx #(
   parameter int CLKS_PER_TICK = 326,
   parameter int ADDR_W        = 4,
   parameter int DATA_W        = 4,
   parameter bit PARITY_ODD    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Rx,
   input  logic              wr_ack,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_valid,
   output logic [8:0]        frame_data,
   output logic [2:0]        err_status
);

   generate
      if (ADDR_W + DATA_W != 8) begin : g_bad_split
         $error("uart_cmd_rx: ADDR_W + DATA_W must equal 8");
      end
      if (CLKS_PER_TICK < 2 || CLKS_PER_TICK > 65535) begin : g_bad_tick
         $error("uart_cmd_rx: CLKS_PER_TICK must be within 2..65535");
      end
   endgenerate

   localparam logic [15:0] TICK_MAX = 16'(CLKS_PER_TICK - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_CMD_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_prev;
   logic [15:0] tick_cnt;
   logic        tick;
   logic [3:0]  phase;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;
   logic        stop_wait;
   logic        framing_err;
   logic        overrun;
   logic        fall;
`ifdef UART_CMD_RX_PARITY_EN
   logic        par_bit;
   logic        par_bad;
   logic        parity_err;
`endif

   assign tick = (tick_cnt == TICK_MAX);
   assign fall = rx_prev & ~rx_sync;

`ifdef UART_CMD_RX_PARITY_EN
   assign err_status = {overrun, parity_err, framing_err};
`else
   assign err_status = {overrun, 1'b0, framing_err};
`endif

   // Bring the asynchronous line into the clock domain and keep one extra stage for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= Rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Free-running oversample tick generator.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Receive FSM together with the command handshake, sticky errors and debug frame capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         stop_wait   <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
         frame_valid <= 1'b0;
         frame_data  <= '0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
`ifdef UART_CMD_RX_PARITY_EN
         par_bit     <= 1'b0;
         par_bad     <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         frame_valid <= 1'b0;
         if (wr_valid && wr_ack) begin
            wr_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (fall) begin
                  state     <= START;
                  phase     <= '0;
                  stop_wait <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
                  par_bad   <= 1'b0;
`endif
               end
            end
            START: begin
               if (tick) begin
                  if (phase == 4'd7) begin
                     phase   <= '0;
                     bit_idx <= '0;
                     state   <= rx_sync ? IDLE : DATA;
                  end else begin
                     phase <= phase + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (phase == 4'd15) begin
                     phase     <= '0;
                     shift_reg <= {rx_sync, shift_reg[7:1]};
                     bit_idx   <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     phase <= phase + 4'd1;
                  end
               end
            end
`ifdef UART_CMD_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (phase == 4'd15) begin
                     phase   <= '0;
                     par_bit <= rx_sync;
                     state   <= STOP;
                     if ((^shift_reg ^ rx_sync) != PARITY_ODD) begin
                        parity_err <= 1'b1;
                        par_bad    <= 1'b1;
                     end
                  end else begin
                     phase <= phase + 4'd1;
                  end
               end
            end
`endif
            STOP: begin
               if (stop_wait) begin
                  if (rx_sync) begin
                     state <= IDLE;
                  end
               end else if (tick) begin
                  if (phase == 4'd15) begin
                     phase <= '0;
                     if (!rx_sync) begin
                        framing_err <= 1'b1;
                        stop_wait   <= 1'b1;
                     end else begin
                        state <= IDLE;
`ifdef UART_CMD_RX_PARITY_EN
                        if (!par_bad) begin
                           frame_valid <= 1'b1;
                           frame_data  <= {par_bit, shift_reg};
`else
                        begin
                           frame_valid <= 1'b1;
                           frame_data  <= {1'b0, shift_reg};
`endif
                           if (!wr_valid || wr_ack) begin
                              wr_valid <= 1'b1;
                              wr_addr  <= shift_reg[7:DATA_W];
                              wr_data  <= shift_reg[DATA_W-1:0];
                           end else begin
                              overrun <= 1'b1;
                           end
                        end
                     end
                  end else begin
                     phase <= phase + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed frames into uart_cmd_rx with a frame scoreboard
// and direct checks of the command handshake and error flags.
module tb_uart_cmd_rx;

   localparam int CLKS = 4;
   localparam int BITT = 16 * CLKS;
`ifdef UART_CMD_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // Negedges from the start-bit drive to the one just before the stop-sample edge,
   // when the start bit is driven one cycle after a known tick edge.
   localparam int ACK_DLY = 4 * (8 + 16 * (8 + PAR_BITS) + 16) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       Rx = 1'b1;
   logic       wr_ack = 1'b0;
   logic       wr_valid;
   logic [3:0] wr_addr;
   logic [3:0] wr_data;
   logic       frame_valid;
   logic [8:0] frame_data;
   logic [2:0] err_status;

   int         vectors = 0;
   int         miscompares = 0;
   logic [8:0] sb[$];
   logic [8:0] mon_exp;
   longint     cyc = 0;
   longint     fv_cyc = 0;

   uart_cmd_rx #(
      .CLKS_PER_TICK(CLKS),
      .ADDR_W(4),
      .DATA_W(4),
      .PARITY_ODD(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .Rx(Rx),
      .wr_ack(wr_ack),
      .wr_valid(wr_valid),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .frame_valid(frame_valid),
      .frame_data(frame_data),
      .err_status(err_status)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used to recover the receiver's tick phase from a frame_valid pulse.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Frame monitor: every frame_valid pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cyc = cyc;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL frame_unexpected: got frame_data=0x%03h, required no frame", frame_data);
         end else begin
            mon_exp = sb.pop_front();
            if (frame_data !== mon_exp) begin
               miscompares++;
               $display("[TB] FAIL frame_data: got 0x%03h, required 0x%03h", frame_data, mon_exp);
            end
         end
      end
   end

   function automatic logic parityOf(input logic [7:0] b);
      return ^b;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Drives one frame; a good frame (stop high, parity correct) is queued for the monitor.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic flip_par);
      logic       pb;
      logic [8:0] fexp;
      pb   = parityOf(b) ^ flip_par;
      fexp = {(PAR_BITS != 0) ? pb : 1'b0, b};
      if (stop_bit && !(flip_par && PAR_BITS != 0)) begin
         sb.push_back(fexp);
      end
      Rx = 1'b0;
      repeat (BITT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         Rx = b[i];
         repeat (BITT) @(negedge clk);
      end
`ifdef UART_CMD_RX_PARITY_EN
      Rx = pb;
      repeat (BITT) @(negedge clk);
`endif
      Rx = stop_bit;
      repeat (BITT) @(negedge clk);
      Rx = 1'b1;
      repeat (2 * BITT) @(negedge clk);
   endtask

   task automatic ackPulse();
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("rst_wr_valid", 16'(wr_valid), 16'h0);
      checkOutput("rst_wr_addr", 16'(wr_addr), 16'h0);
      checkOutput("rst_wr_data", 16'(wr_data), 16'h0);
      checkOutput("rst_frame_valid", 16'(frame_valid), 16'h0);
      checkOutput("rst_frame_data", 16'(frame_data), 16'h0);
      checkOutput("rst_err_status", 16'(err_status), 16'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      applyStimulus(8'hA5, 1'b1, 1'b0);
      checkOutput("a5_wr_valid", 16'(wr_valid), 16'h1);
      checkOutput("a5_wr_addr", 16'(wr_addr), 16'hA);
      checkOutput("a5_wr_data", 16'(wr_data), 16'h5);
      repeat (20) @(negedge clk);
      checkOutput("a5_valid_held", 16'(wr_valid), 16'h1);
      checkOutput("a5_addr_held", 16'(wr_addr), 16'hA);
      ackPulse();
      checkOutput("a5_valid_drop", 16'(wr_valid), 16'h0);
      checkOutput("a5_err_status", 16'(err_status), 16'h0);

      applyStimulus(8'h12, 1'b0, 1'b0);
      checkOutput("framing_err_status", 16'(err_status), 16'h1);
      checkOutput("framing_no_valid", 16'(wr_valid), 16'h0);
      applyStimulus(8'h34, 1'b1, 1'b0);
      checkOutput("34_wr_valid", 16'(wr_valid), 16'h1);
      checkOutput("34_wr_addr", 16'(wr_addr), 16'h3);
      checkOutput("34_wr_data", 16'(wr_data), 16'h4);
      ackPulse();
      checkOutput("34_valid_drop", 16'(wr_valid), 16'h0);

      applyStimulus(8'h11, 1'b1, 1'b0);
      checkOutput("11_wr_addr", 16'(wr_addr), 16'h1);
      checkOutput("11_wr_data", 16'(wr_data), 16'h1);
      applyStimulus(8'h22, 1'b1, 1'b0);
      checkOutput("overrun_err_status", 16'(err_status), 16'h5);
      checkOutput("overrun_wr_valid", 16'(wr_valid), 16'h1);
      checkOutput("overrun_wr_addr", 16'(wr_addr), 16'h1);
      checkOutput("overrun_wr_data", 16'(wr_data), 16'h1);

      for (int k = 0; k < 8 && ((cyc - fv_cyc) % 4) != 0; k++) @(negedge clk);
      fork
         applyStimulus(8'h33, 1'b1, 1'b0);
         begin
            repeat (ACK_DLY) @(negedge clk);
            wr_ack = 1'b1;
            @(negedge clk);
            wr_ack = 1'b0;
            checkOutput("ack_coincident_frame", 16'(frame_valid), 16'h1);
            checkOutput("ack_coincident_valid", 16'(wr_valid), 16'h1);
         end
      join
      checkOutput("33_wr_valid", 16'(wr_valid), 16'h1);
      checkOutput("33_wr_addr", 16'(wr_addr), 16'h3);
      checkOutput("33_wr_data", 16'(wr_data), 16'h3);
      checkOutput("33_err_status", 16'(err_status), 16'h5);
      ackPulse();
      checkOutput("33_valid_drop", 16'(wr_valid), 16'h0);

      Rx = 1'b0;
      repeat (4 * CLKS) @(negedge clk);
      Rx = 1'b1;
      repeat (3 * BITT) @(negedge clk);
      checkOutput("glitch_err_status", 16'(err_status), 16'h5);
      checkOutput("glitch_wr_valid", 16'(wr_valid), 16'h0);

      Rx = 1'b0;
      repeat (BITT) @(negedge clk);
      Rx = 1'b0;
      repeat (BITT) @(negedge clk);
      Rx = 1'b1;
      repeat (BITT / 2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midrst_wr_valid", 16'(wr_valid), 16'h0);
      checkOutput("midrst_wr_addr", 16'(wr_addr), 16'h0);
      checkOutput("midrst_wr_data", 16'(wr_data), 16'h0);
      checkOutput("midrst_frame_data", 16'(frame_data), 16'h0);
      checkOutput("midrst_err_status", 16'(err_status), 16'h0);
      rst = 1'b0;
      repeat (2 * BITT) @(negedge clk);
      checkOutput("midrst_quiet_err", 16'(err_status), 16'h0);
      applyStimulus(8'h5A, 1'b1, 1'b0);
      checkOutput("5a_wr_valid", 16'(wr_valid), 16'h1);
      checkOutput("5a_wr_addr", 16'(wr_addr), 16'h5);
      checkOutput("5a_wr_data", 16'(wr_data), 16'hA);
      ackPulse();

`ifdef UART_CMD_RX_PARITY_EN
      applyStimulus(8'h3C, 1'b1, 1'b1);
      checkOutput("parity_err_status", 16'(err_status), 16'h2);
      checkOutput("parity_wr_valid", 16'(wr_valid), 16'h0);
`endif

      repeat (10) @(negedge clk);
      checkOutput("frames_outstanding", 16'(sb.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLKS_PER_TICK, default 326, SHALL set the number of clk cycles per 16x-oversample tick (legal range 2..65535).
REQ-002 Parameter ADDR_W, default 4, SHALL set the width of the address field taken from each received byte.
REQ-003 Parameter DATA_W, default 4, SHALL set the width of the data field; ADDR_W+DATA_W SHALL equal 8, and elaboration SHALL fail otherwise.
REQ-004 Parameter PARITY_ODD, default 0, SHALL select parity sense when parity is compiled in: 0 = even, 1 = odd.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock.
REQ-006 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-007 Port Rx, input, 1 bit, SHALL carry the asynchronous serial line, idle high.
REQ-008 Port wr_ack, input, 1 bit, SHALL signal consumer acceptance of the pending command.
REQ-009 Port wr_valid, output, 1 bit, SHALL flag a pending decoded command.
REQ-010 Port wr_addr, output, ADDR_W bits, SHALL carry byte[7:DATA_W].
REQ-011 Port wr_data, output, DATA_W bits, SHALL carry byte[DATA_W-1:0].
REQ-012 Port frame_valid, output, 1 bit, SHALL pulse one cycle per correctly received byte.
REQ-013 Port frame_data, output, 9 bits, SHALL hold {parity_bit_or_0, byte} of the last good frame (debug).
REQ-014 Port err_status, output, 3 bits, SHALL hold sticky {overrun, parity_err, framing_err}.

Function
REQ-015 Rx SHALL pass through a 2-flop synchroniser before use; all sampling SHALL use the synchronised value.
REQ-016 A tick counter SHALL count 0..CLKS_PER_TICK-1 and emit a one-cycle tick at wrap; it SHALL free-run except during reset.
REQ-017 The receive FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on a synchronised falling edge; tick phase counter cleared to 0.
REQ-019 START: at the 8th tick, line low -> DATA; line high -> IDLE (glitch), no error flagged.
REQ-020 DATA: 8 bits sampled LSB first, each at 16 ticks after the previous sample; after bit 7 -> PARITY if compiled in, else STOP.
REQ-021 PARITY: one bit sampled 16 ticks later; a mismatch against the selected parity sets parity_err and the byte SHALL be discarded.
REQ-022 STOP: bit sampled 16 ticks later; low -> framing_err set, byte discarded, FSM waits in STOP until the line is high and then -> IDLE; high -> frame accepted, FSM -> IDLE.
REQ-023 On accept, frame_valid SHALL pulse in the cycle after the stop sample and frame_data SHALL update in the same cycle.
REQ-024 On accept with wr_valid low, wr_valid SHALL rise in that same cycle with wr_addr and wr_data loaded.
REQ-025 wr_valid, wr_addr and wr_data SHALL stay stable until a cycle with wr_valid&wr_ack; wr_valid SHALL drop in the following cycle.
REQ-026 On accept while wr_valid is high and wr_ack is low, the new byte SHALL be dropped, overrun set, and the pending command left unchanged.
REQ-027 On accept in the same cycle as wr_valid&wr_ack, the new byte SHALL replace the pending command, wr_valid SHALL stay high, and no overrun SHALL be raised.
REQ-028 wr_ack while wr_valid is low SHALL be ignored.
REQ-029 err_status bits SHALL be cleared only by reset.

Reset
REQ-030 With rst high at a clk edge: FSM -> IDLE; tick and bit counters = 0; synchroniser flops = 1; wr_valid = 0; wr_addr = 0; wr_data = 0; frame_valid = 0; frame_data = 0; err_status = 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no output or error; after release, reception SHALL start only on a fresh falling edge.

Configuration
REQ-032 Macro UART_CMD_RX_PARITY_EN defined: the frame SHALL be start + 8 data + parity + stop; frame_data[8] SHALL hold the received parity bit; parity_err SHALL be active.
REQ-033 Macro undefined: the frame SHALL be start + 8 data + stop; the PARITY state SHALL be absent; frame_data[8] SHALL be 0; err_status[1] SHALL be tied to 0; PARITY_ODD SHALL be ignored.

Verification
REQ-034 CLKS_PER_TICK=4, no parity, send 0xA5 -> one frame_valid, frame_data=0x0A5, wr_addr=0xA, wr_data=0x5, wr_valid held until wr_ack.
REQ-035 Parity enabled, even, send 0x3C with parity=1 -> parity_err=1, no frame_valid, wr_valid stays 0.
REQ-036 Send 0x12 with stop bit low -> framing_err=1, byte discarded; then a clean 0x34 -> wr_addr=0x3, wr_data=0x4.
REQ-037 Send 0x11, hold wr_ack=0, send 0x22 -> overrun=1, outputs remain 0x1/0x1; assert wr_ack coincident with a 0x33 accept -> wr_valid stays high with 0x3/0x3 and overrun does not toggle.
REQ-038 Low pulse of 4 ticks on Rx -> FSM returns to IDLE, no error; assert rst mid-byte -> all outputs 0, next full frame received correctly.
